cond_ctrl_pipe: RTL and testbench
=================================

Name: cond_ctrl_pipe

Overview:
Parametrised control-signal pipeline placed after the decode-stage control unit. It carries the decoded control bundle through the Execute, Memory and Writeback pipeline registers. It evaluates the ARM 4-bit condition field against an internal NZCV flags register in Execute and squashes the side effects of failed instructions. It also supports Execute-stage stall and flush for the hazard unit.

Parameters:
ALUCTRL_W, 4, width of ALU control field carried D->E
CNT_W, 32, width of performance counters (used only with PERF_CNT_EN)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous reset, active-low (reset==0 resets)
ValidD  input  1  D-stage holds a real instruction
CondD  input  4  condition field Instr[31:28]
PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, NoWriteD  input  1 each  decoded controls
ALUControlD  input  ALUCTRL_W  ALU operation
FlagWriteD  input  2  [1]=update N,Z; [0]=update C,V
StallE  input  1  hold E register
FlushE  input  1  insert bubble into E
ALUFlagsE  input  4  NZCV from ALU ({N,Z,C,V})
ALUControlE  output  ALUCTRL_W  to ALU
ALUSrcE, MemtoRegE  output  1 each  E-stage controls (MemtoRegE for load-use detection)
CondExE  output  1  condition passed for valid E instruction
BranchTakenE  output  1  BranchE & CondExE
RegWriteM, MemWriteM, MemtoRegM, PCSrcM  output  1 each  M-stage controls
RegWriteW, MemtoRegW, PCSrcW  output  1 each  W-stage controls
FlagsQ  output  4  architectural NZCV register
RetiredCnt, SquashCnt  output  CNT_W each  present only with PERF_CNT_EN

Behaviour:
- Reset (async, reset==0): all E/M/W control registers, ValidE, and FlagsQ cleared to 0; all outputs 0.
- E register update on clk:
  - FlushE=1 loads a bubble (all controls 0, ValidE=0, CondE=4'b1110). FlushE overrides StallE.
  - Otherwise, StallE=1 holds the register.
  - Otherwise, loads the D inputs.
- Condition evaluation is combinational on CondE and FlagsQ:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL (1110) 1; 1111 treated as 1.
- CondExE = CondPass & ValidE.
- Gating into M (M loads every cycle):
  - PCSrcM <= PCSrcE & CondExE
  - RegWriteM <= RegWriteE & CondExE & !NoWriteE
  - MemWriteM <= MemWriteE & CondExE
  - MemtoRegM <= MemtoRegE
- While StallE=1, M loads a bubble (all 0) so the held instruction is never issued twice.
- M->W copies RegWrite, MemtoReg and PCSrc every cycle; no stall or flush on M or W.
- Flags update at the clk edge when CondExE & !StallE:
  - FlagWriteE[1] loads N,Z from ALUFlagsE.
  - FlagWriteE[0] loads C,V from ALUFlagsE.
  - Partial writes leave the other pair unchanged.
- Latency: D->E 1 cycle, E->M 1, M->W 1. FlagsQ is visible to the next instruction in E with no bubble.
- Simultaneous events:
  - FlushE with a failing-condition E instruction: M receives the gated (zero) E controls; E becomes a bubble.
  - Reset asserted mid-instruction: everything in flight is discarded immediately, without waiting for a clock edge.

Optional Feature:
PERF_CNT_EN:
- Defined: CNT_W-bit RetiredCnt and SquashCnt exist as outputs, reset to 0.
  - RetiredCnt increments on each cycle with ValidE & CondPass & !StallE.
  - SquashCnt increments on each cycle with ValidE & !CondPass & !StallE.
  - Both wrap to 0 after all-ones.
- Undefined: counters and ports absent; all other behaviour identical.

Test Plan:
- Reset with reset=0 mid-stream carrying RegWriteD=1 -> all outputs 0 immediately (before next edge); FlagsQ=0000.
- FlagsQ=0100 (Z=1), E has CondE=0000 (EQ), RegWriteE=1 -> RegWriteM=1 next cycle, RegWriteW=1 one cycle later. Same with CondE=0001 (NE) -> RegWriteM=0.
- CMP with FlagWriteD=11, NoWriteD=1, ALUFlagsE=1001 -> FlagsQ=1001 next cycle, RegWriteM=0. Following BGE (CondE=1010, BranchE=1) -> BranchTakenE=1.
- FlagWriteE=10 with ALUFlagsE=0111 from FlagsQ=1001 -> FlagsQ=0101 (N,Z updated, C,V kept).
- StallE=1 for 2 cycles with a MemWriteE=1/AL instruction -> MemWriteM=0 during the stall, then exactly one MemWriteM=1 pulse after StallE drops. StallE=1 with FlushE=1 -> ValidE=0.
- PERF_CNT_EN defined: 3 passing and 2 failing valid instructions with no stalls -> RetiredCnt=3, SquashCnt=2. Counter preset at all-ones plus one more passing instruction -> RetiredCnt wraps to 0.

Source files
------------

// File: rtl/cond_ctrl_pipe.sv
// ============================================================================
//  Module   : cond_ctrl_pipe
//  Purpose  : E/M/W control pipeline with ARM condition evaluation, NZCV
//             flags register, E-stage stall/flush. Optional macro PERF_CNT_EN
//             adds retired/squashed instruction counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cond_ctrl_pipe #(
  parameter int ALUCTRL_W = 4
`ifdef PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ValidD,
  input  logic [3:0]           CondD,
  input  logic                 PCSrcD,
  input  logic                 RegWriteD,
  input  logic                 MemtoRegD,
  input  logic                 MemWriteD,
  input  logic                 BranchD,
  input  logic                 ALUSrcD,
  input  logic                 NoWriteD,
  input  logic [ALUCTRL_W-1:0] ALUControlD,
  input  logic [1:0]           FlagWriteD,
  input  logic                 StallE,
  input  logic                 FlushE,
  input  logic [3:0]           ALUFlagsE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 ALUSrcE,
  output logic                 MemtoRegE,
  output logic                 CondExE,
  output logic                 BranchTakenE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic                 MemtoRegM,
  output logic                 PCSrcM,
  output logic                 RegWriteW,
  output logic                 MemtoRegW,
  output logic                 PCSrcW,
  output logic [3:0]           FlagsQ
`ifdef PERF_CNT_EN
  , output logic [CNT_W-1:0]   RetiredCnt,
  output logic [CNT_W-1:0]     SquashCnt
`endif
);

  localparam logic [3:0] c_COND_AL = 4'b1110;

  // E-stage register
  logic                 r_validE;
  logic [3:0]           r_condE;
  logic                 r_pcSrcE;
  logic                 r_regWriteE;
  logic                 r_memtoRegE;
  logic                 r_memWriteE;
  logic                 r_branchE;
  logic                 r_aluSrcE;
  logic                 r_noWriteE;
  logic [ALUCTRL_W-1:0] r_aluControlE;
  logic [1:0]           r_flagWriteE;

  // M/W-stage registers and flags
  logic       r_regWriteM;
  logic       r_memWriteM;
  logic       r_memtoRegM;
  logic       r_pcSrcM;
  logic       r_regWriteW;
  logic       r_memtoRegW;
  logic       r_pcSrcW;
  logic [3:0] r_flags;

  logic w_condPass;
  logic w_condExE;
  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_condPass = 1'b1;
    case (r_condE)
      4'b0000: w_condPass = w_z;
      4'b0001: w_condPass = !w_z;
      4'b0010: w_condPass = w_c;
      4'b0011: w_condPass = !w_c;
      4'b0100: w_condPass = w_n;
      4'b0101: w_condPass = !w_n;
      4'b0110: w_condPass = w_v;
      4'b0111: w_condPass = !w_v;
      4'b1000: w_condPass = w_c && !w_z;
      4'b1001: w_condPass = !w_c || w_z;
      4'b1010: w_condPass = (w_n == w_v);
      4'b1011: w_condPass = (w_n != w_v);
      4'b1100: w_condPass = !w_z && (w_n == w_v);
      4'b1101: w_condPass = w_z || (w_n != w_v);
      default: w_condPass = 1'b1;
    endcase
  end

  assign w_condExE = w_condPass && r_validE;

  // Flush wins over stall so the hazard unit can always kill the E slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_validE      <= 1'b0;
      r_condE       <= 4'b0000;
      r_pcSrcE      <= 1'b0;
      r_regWriteE   <= 1'b0;
      r_memtoRegE   <= 1'b0;
      r_memWriteE   <= 1'b0;
      r_branchE     <= 1'b0;
      r_aluSrcE     <= 1'b0;
      r_noWriteE    <= 1'b0;
      r_aluControlE <= '0;
      r_flagWriteE  <= 2'b00;
    end else if (FlushE) begin
      r_validE      <= 1'b0;
      r_condE       <= c_COND_AL;
      r_pcSrcE      <= 1'b0;
      r_regWriteE   <= 1'b0;
      r_memtoRegE   <= 1'b0;
      r_memWriteE   <= 1'b0;
      r_branchE     <= 1'b0;
      r_aluSrcE     <= 1'b0;
      r_noWriteE    <= 1'b0;
      r_aluControlE <= '0;
      r_flagWriteE  <= 2'b00;
    end else if (!StallE) begin
      r_validE      <= ValidD;
      r_condE       <= CondD;
      r_pcSrcE      <= PCSrcD;
      r_regWriteE   <= RegWriteD;
      r_memtoRegE   <= MemtoRegD;
      r_memWriteE   <= MemWriteD;
      r_branchE     <= BranchD;
      r_aluSrcE     <= ALUSrcD;
      r_noWriteE    <= NoWriteD;
      r_aluControlE <= ALUControlD;
      r_flagWriteE  <= FlagWriteD;
    end
  end

  // A stalled E instruction is still in E next cycle, so M must not see it yet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regWriteM <= 1'b0;
      r_memWriteM <= 1'b0;
      r_memtoRegM <= 1'b0;
      r_pcSrcM    <= 1'b0;
    end else if (StallE) begin
      r_regWriteM <= 1'b0;
      r_memWriteM <= 1'b0;
      r_memtoRegM <= 1'b0;
      r_pcSrcM    <= 1'b0;
    end else begin
      r_regWriteM <= r_regWriteE && w_condExE && !r_noWriteE;
      r_memWriteM <= r_memWriteE && w_condExE;
      r_memtoRegM <= r_memtoRegE;
      r_pcSrcM    <= r_pcSrcE && w_condExE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regWriteW <= 1'b0;
      r_memtoRegW <= 1'b0;
      r_pcSrcW    <= 1'b0;
    end else begin
      r_regWriteW <= r_regWriteM;
      r_memtoRegW <= r_memtoRegM;
      r_pcSrcW    <= r_pcSrcM;
    end
  end

  // N,Z and C,V are written independently so partial flag setters keep the rest
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 4'b0000;
    end else if (w_condExE && !StallE) begin
      if (r_flagWriteE[1]) r_flags[3:2] <= ALUFlagsE[3:2];
      if (r_flagWriteE[0]) r_flags[1:0] <= ALUFlagsE[1:0];
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_retiredCnt;
  logic [CNT_W-1:0] r_squashCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retiredCnt <= '0;
      r_squashCnt  <= '0;
    end else if (r_validE && !StallE) begin
      if (w_condPass) r_retiredCnt <= r_retiredCnt + CNT_W'(1);
      else            r_squashCnt  <= r_squashCnt + CNT_W'(1);
    end
  end

  assign RetiredCnt = r_retiredCnt;
  assign SquashCnt  = r_squashCnt;
`endif

  assign ALUControlE  = r_aluControlE;
  assign ALUSrcE      = r_aluSrcE;
  assign MemtoRegE    = r_memtoRegE;
  assign CondExE      = w_condExE;
  assign BranchTakenE = r_branchE && w_condExE;
  assign RegWriteM    = r_regWriteM;
  assign MemWriteM    = r_memWriteM;
  assign MemtoRegM    = r_memtoRegM;
  assign PCSrcM       = r_pcSrcM;
  assign RegWriteW    = r_regWriteW;
  assign MemtoRegW    = r_memtoRegW;
  assign PCSrcW       = r_pcSrcW;
  assign FlagsQ       = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_cond_ctrl_pipe.sv
// ============================================================================
//  Module   : tb_cond_ctrl_pipe
//  Purpose  : Directed plus randomized bench for cond_ctrl_pipe against a
//             stage-level reference model. Honours PERF_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cond_ctrl_pipe;

  localparam int ALUCTRL_W = 4;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic                 valid;
    logic [3:0]           cond;
    logic                 pcSrc;
    logic                 regWrite;
    logic                 memtoReg;
    logic                 memWrite;
    logic                 branch;
    logic                 aluSrc;
    logic                 noWrite;
    logic [ALUCTRL_W-1:0] aluCtrl;
    logic [1:0]           flagWrite;
  } instr_t;

  logic                 clk = 1'b0;
  logic                 reset;
  instr_t               dIn;
  logic                 stallE;
  logic                 flushE;
  logic [3:0]           aluFlags;
  logic [ALUCTRL_W-1:0] ALUControlE;
  logic ALUSrcE, MemtoRegE, CondExE, BranchTakenE;
  logic RegWriteM, MemWriteM, MemtoRegM, PCSrcM;
  logic RegWriteW, MemtoRegW, PCSrcW;
  logic [3:0]           FlagsQ;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0]     RetiredCnt;
  logic [CNT_W-1:0]     SquashCnt;
`endif

  int nCompared = 0;
  int nMismatch = 0;

  // Reference model state, one record per pipeline stage
  instr_t mE;
  logic [3:0] mFlags;
  logic mRegWriteM, mMemWriteM, mMemtoRegM, mPcSrcM;
  logic mRegWriteW, mMemtoRegW, mPcSrcW;
  int mRetired, mSquash;

  cond_ctrl_pipe #(
    .ALUCTRL_W(ALUCTRL_W)
`ifdef PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) dut (
    .clk(clk), .reset(reset),
    .ValidD(dIn.valid), .CondD(dIn.cond), .PCSrcD(dIn.pcSrc),
    .RegWriteD(dIn.regWrite), .MemtoRegD(dIn.memtoReg), .MemWriteD(dIn.memWrite),
    .BranchD(dIn.branch), .ALUSrcD(dIn.aluSrc), .NoWriteD(dIn.noWrite),
    .ALUControlD(dIn.aluCtrl), .FlagWriteD(dIn.flagWrite),
    .StallE(stallE), .FlushE(flushE), .ALUFlagsE(aluFlags),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .MemtoRegE(MemtoRegE),
    .CondExE(CondExE), .BranchTakenE(BranchTakenE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .PCSrcM(PCSrcM),
    .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .PCSrcW(PCSrcW),
    .FlagsQ(FlagsQ)
`ifdef PERF_CNT_EN
    , .RetiredCnt(RetiredCnt), .SquashCnt(SquashCnt)
`endif
  );

  always #5 clk = ~clk;

  // ARM pairs conditions: odd codes negate the even code below them (AL/1111 always pass)
  function automatic logic refPass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic instr_t mk(input logic [3:0] cond, input logic regWrite,
                                input logic memWrite, input logic noWrite,
                                input logic branch, input logic [1:0] flagWrite);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.cond = cond; i.regWrite = regWrite; i.memWrite = memWrite;
    i.noWrite = noWrite; i.branch = branch; i.flagWrite = flagWrite;
    return i;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatch++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mE = '0; mFlags = 4'b0000;
    {mRegWriteM, mMemWriteM, mMemtoRegM, mPcSrcM} = 4'b0000;
    {mRegWriteW, mMemtoRegW, mPcSrcW} = 3'b000;
    mRetired = 0; mSquash = 0;
  endtask

  task automatic modelEdge();
    logic ex, pass;
    if (!reset) begin
      modelReset();
      return;
    end
    pass = refPass(mE.cond, mFlags);
    ex   = pass && mE.valid;
    if (mE.valid && !stallE) begin
      if (pass) mRetired = (mRetired + 1) % (1 << CNT_W);
      else      mSquash  = (mSquash + 1) % (1 << CNT_W);
    end
    {mRegWriteW, mMemtoRegW, mPcSrcW} = {mRegWriteM, mMemtoRegM, mPcSrcM};
    if (stallE) {mRegWriteM, mMemWriteM, mMemtoRegM, mPcSrcM} = 4'b0000;
    else begin
      mRegWriteM = mE.regWrite && ex && !mE.noWrite;
      mMemWriteM = mE.memWrite && ex;
      mMemtoRegM = mE.memtoReg;
      mPcSrcM    = mE.pcSrc && ex;
    end
    if (ex && !stallE) begin
      if (mE.flagWrite[1]) mFlags[3:2] = aluFlags[3:2];
      if (mE.flagWrite[0]) mFlags[1:0] = aluFlags[1:0];
    end
    if (flushE) begin
      mE = '0;
      mE.cond = 4'b1110;
    end else if (!stallE) begin
      mE = dIn;
    end
  endtask

  task automatic checkAll();
    logic ex;
    ex = refPass(mE.cond, mFlags) && mE.valid;
    check("ALUControlE", 32'(ALUControlE), 32'(mE.aluCtrl));
    check("ALUSrcE", 32'(ALUSrcE), 32'(mE.aluSrc));
    check("MemtoRegE", 32'(MemtoRegE), 32'(mE.memtoReg));
    check("CondExE", 32'(CondExE), 32'(ex));
    check("BranchTakenE", 32'(BranchTakenE), 32'(mE.branch && ex));
    check("RegWriteM", 32'(RegWriteM), 32'(mRegWriteM));
    check("MemWriteM", 32'(MemWriteM), 32'(mMemWriteM));
    check("MemtoRegM", 32'(MemtoRegM), 32'(mMemtoRegM));
    check("PCSrcM", 32'(PCSrcM), 32'(mPcSrcM));
    check("RegWriteW", 32'(RegWriteW), 32'(mRegWriteW));
    check("MemtoRegW", 32'(MemtoRegW), 32'(mMemtoRegW));
    check("PCSrcW", 32'(PCSrcW), 32'(mPcSrcW));
    check("FlagsQ", 32'(FlagsQ), 32'(mFlags));
`ifdef PERF_CNT_EN
    check("RetiredCnt", 32'(RetiredCnt), 32'(mRetired));
    check("SquashCnt", 32'(SquashCnt), 32'(mSquash));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic issue(input instr_t i);
    dIn = i; stallE = 1'b0; flushE = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b0; dIn = '0; stallE = 1'b0; flushE = 1'b0; aluFlags = 4'b0000;
    modelReset();
    #1;
    checkAll();
    step();
    step();
    reset = 1'b1;

    // CMP sets NZCV=1001, then BGE sees N==V
    aluFlags = 4'b0000;
    issue(mk(4'b1110, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11));
    aluFlags = 4'b1001;
    issue(mk(4'b1010, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
    check("cmp_flags", 32'(FlagsQ), 32'h9);
    check("cmp_nowrite", 32'(RegWriteM), 32'h0);
    check("bge_taken", 32'(BranchTakenE), 32'h1);

    // N,Z-only update keeps C,V
    aluFlags = 4'b0000;
    issue(mk(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10));
    aluFlags = 4'b0111;
    issue('0);
    check("partial_flags", 32'(FlagsQ), 32'h5);

    // EQ passes and NE fails with Z=1
    aluFlags = 4'b0000;
    issue(mk(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    issue(mk(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    check("eq_regwrite_m", 32'(RegWriteM), 32'h1);
    issue('0);
    check("ne_regwrite_m", 32'(RegWriteM), 32'h0);
    check("eq_regwrite_w", 32'(RegWriteW), 32'h1);

    // Two-cycle stall on an AL store: exactly one MemWriteM pulse
    issue(mk(4'b1110, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
    dIn = '0; stallE = 1'b1;
    step();
    check("stall_memw_0", 32'(MemWriteM), 32'h0);
    step();
    check("stall_memw_1", 32'(MemWriteM), 32'h0);
    issue('0);
    check("stall_memw_pulse", 32'(MemWriteM), 32'h1);
    issue('0);
    check("stall_memw_after", 32'(MemWriteM), 32'h0);

    // Flush overrides stall
    issue(mk(4'b1110, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    dIn = '0; stallE = 1'b1; flushE = 1'b1;
    step();
    check("flush_over_stall", 32'(CondExE), 32'h0);

    // Counters from a clean reset: 3 pass, 2 fail (Z=0 so EQ fails)
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++)
      issue(mk((k < 3) ? 4'b1110 : 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00));
    issue('0);
`ifdef PERF_CNT_EN
    check("retired_3", 32'(RetiredCnt), 32'd3);
    check("squash_2", 32'(SquashCnt), 32'd2);
`endif
    for (int k = 0; k < 12; k++) issue(mk(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    issue('0);
`ifdef PERF_CNT_EN
    check("retired_allones", 32'(RetiredCnt), 32'hf);
`endif
    issue(mk(4'b1110, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00));
    issue('0);
`ifdef PERF_CNT_EN
    check("retired_wrap", 32'(RetiredCnt), 32'h0);
`endif

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      dIn = instr_t'({$urandom, $urandom});
      dIn.valid = ($urandom_range(3) != 0);
      stallE    = ($urandom_range(4) == 0);
      flushE    = ($urandom_range(7) == 0);
      aluFlags  = 4'($urandom);
      step();
    end

    // Asynchronous reset between edges while writes are in flight
    for (int k = 0; k < 3; k++) issue(mk(4'b1110, 1'b1, 1'b1, 1'b0, 1'b0, 2'b11));
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    check("async_rst_regw_m", 32'(RegWriteM), 32'h0);
    check("async_rst_flags", 32'(FlagsQ), 32'h0);
    step();
    reset = 1'b1;
    issue('0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

`default_nettype wire
